// File: rtl/spi_mbox_reader.sv
// Mailbox port-B consumer: polls RAM slots for pending commands, runs each as a 16-bit
// SPI mode-0 transfer and writes the completed word back. Optional irq port: SPI_MBOX_IRQ_EN.
module spi_mbox_reader #(
  parameter int unsigned SLOTS   = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        enb,
  output logic        web,
  output logic [7:0]  addrb,
  output logic [31:0] dib,
  input  logic [31:0] dob,
  input  logic        ackb,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic        busy
`ifdef SPI_MBOX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PH_W       = 6;
  localparam int unsigned PH_SCLK_LO = 2;
  localparam int unsigned PH_SCLK_HI = 32;
  localparam int unsigned PH_LAST    = 33;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    DECODE,
    SHIFT,
    WRBACK,
    WAIT_WR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W-1:0] ptr_inc;
  logic [31:0]       cmd;
  logic [15:0]       frame;
  logic [14:0]       tx_sh;
  logic [7:0]        rx;
  logic [DIV_W-1:0]  div_cnt;
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   phase_inc;
  logic              div_end;
  logic              ph_end;
  logic              sclk_lvl;
  logic              unused_cmd_bits;

  assign ptr_inc   = (ptr == ADDR_W'(SLOTS - 1)) ? '0 : ptr + ADDR_W'(1);
  assign frame     = {cmd[30], cmd[22:16], cmd[15:8]};
  assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign ph_end    = div_end && (phase == PH_W'(PH_LAST));
  assign phase_inc = phase + PH_W'(1);
  // Phase 0/1 is cs_n setup, even phases 2..32 are sclk high, phase 33 is cs_n hold.
  assign sclk_lvl  = (phase_inc >= PH_W'(PH_SCLK_LO)) && (phase_inc <= PH_W'(PH_SCLK_HI))
                     && !phase_inc[0];
  assign unused_cmd_bits = ^{cmd[29], cmd[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT_RD;
      WAIT_RD: if (ackb) state_nxt = DECODE;
      DECODE: begin
        if (!cmd[31]) begin
          ptr_nxt   = ptr_inc;
          state_nxt = run ? FETCH : IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (ph_end) state_nxt = WRBACK;
      WRBACK:  state_nxt = WAIT_WR;
      WAIT_WR: begin
        if (ackb) begin
          ptr_nxt   = ptr_inc;
          state_nxt = run ? FETCH : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port, SPI pins and transfer datapath, all registered off the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb     <= 1'b0;
      web     <= 1'b0;
      addrb   <= '0;
      dib     <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      cmd     <= '0;
      tx_sh   <= '0;
      rx      <= '0;
      div_cnt <= '0;
      phase   <= '0;
    end else begin
      enb  <= (state_nxt == FETCH) || (state_nxt == WRBACK);
      web  <= (state_nxt == WRBACK);
      busy <= (state_nxt != IDLE);
      cs_n <= (state_nxt != SHIFT);
      if ((state_nxt == FETCH) || (state_nxt == WRBACK)) addrb <= ptr_nxt;
      if ((state == WAIT_RD) && ackb) cmd <= dob;
      if ((state == SHIFT) && (state_nxt == WRBACK)) dib <= {1'b0, cmd[30], 1'b1, cmd[28:8], rx};

      if ((state == DECODE) && (state_nxt == SHIFT)) begin
        mosi    <= frame[15];
        tx_sh   <= frame[14:0];
        rx      <= '0;
        sclk    <= 1'b0;
        div_cnt <= '0;
        phase   <= '0;
      end else if (state == SHIFT) begin
        if (div_end) begin
          div_cnt <= '0;
          if (!ph_end) begin
            phase <= phase_inc;
            sclk  <= sclk_lvl;
            if (sclk_lvl && !sclk) rx <= {rx[6:0], miso};
            if (!sclk_lvl && sclk) begin
              mosi  <= tx_sh[14];
              tx_sh <= {tx_sh[13:0], 1'b0};
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

`ifdef SPI_MBOX_IRQ_EN
  // Completion strobe aligned with the write-back acknowledge.
  assign irq = (state == WAIT_WR) && ackb;
`endif

endmodule

// File: tb/tb_spi_mbox_reader.sv
// Bench for spi_mbox_reader: mailbox RAM and SPI slave models, directed vector table
// plus run-drop, reset-mid-transfer and (with SPI_MBOX_IRQ_EN) irq sequences.
module tb_spi_mbox_reader;
  localparam int unsigned SLOTS    = 16;
  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned PEND_LAT = 141;
  localparam int unsigned CS_LOW   = 136;
  localparam int unsigned NVEC     = 5;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        run   = 1'b0;
  logic        enb;
  logic        web;
  logic [7:0]  addrb;
  logic [31:0] dib;
  logic [31:0] dob   = 32'h0;
  logic        ackb  = 1'b0;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso  = 1'b0;
  logic        busy;
`ifdef SPI_MBOX_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  spi_mbox_reader #(.SLOTS(SLOTS), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .enb   (enb),
    .web   (web),
    .addrb (addrb),
    .dib   (dib),
    .dob   (dob),
    .ackb  (ackb),
    .sclk  (sclk),
    .cs_n  (cs_n),
    .mosi  (mosi),
    .miso  (miso),
    .busy  (busy)
`ifdef SPI_MBOX_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  // Mailbox RAM port B with a backdoor write port for preloading.
  logic [31:0] mem [0:SLOTS-1];
  logic        bd_we   = 1'b0;
  logic [3:0]  bd_addr = 4'h0;
  logic [31:0] bd_data = 32'h0;
  always @(posedge clk) begin
    ackb <= enb;
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (enb && web) mem[addrb[3:0]] <= dib;
    if (enb && !web) dob <= mem[addrb[3:0]];
  end

  // Bus/pin monitor and mode-0 SPI slave, evaluated on the quiet clock edge.
  logic [15:0] slave_word = 16'h0;
  logic [15:0] s_tx = 16'h0;
  logic [15:0] s_rx = 16'h0;
  logic        sclk_q = 1'b0;
  logic        cs_q = 1'b1;
  logic        web_q = 1'b0;
  int unsigned cyc = 0, rises = 0, cs_low = 0, fetch_cnt = 0, wr_cnt = 0, enb_cnt = 0;
  int unsigned irq_cnt = 0, irq_bad = 0, last_fetch_cyc = 0;
  logic [7:0]  last_fetch_addr = 8'h0;
  logic [7:0]  last_wr_addr = 8'h0;
  int unsigned fetch_cyc_of [SLOTS];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!cs_n) cs_low <= cs_low + 1;
    if (enb) enb_cnt <= enb_cnt + 1;
    if (enb && !web) begin
      fetch_cnt                <= fetch_cnt + 1;
      last_fetch_addr          <= addrb;
      last_fetch_cyc           <= cyc;
      fetch_cyc_of[addrb[3:0]] <= cyc;
    end
    if (enb && web) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= addrb;
    end
    if (cs_q && !cs_n) begin
      s_tx <= slave_word;
      miso <= slave_word[15];
    end else if (sclk_q && !sclk && !cs_n) begin
      s_tx <= {s_tx[14:0], 1'b0};
      miso <= s_tx[14];
    end
    if (!sclk_q && sclk) begin
      s_rx  <= {s_rx[14:0], mosi};
      rises <= rises + 1;
    end
`ifdef SPI_MBOX_IRQ_EN
    if (irq) irq_cnt <= irq_cnt + 1;
    if (irq !== (ackb && web_q)) irq_bad <= irq_bad + 1;
`endif
    sclk_q <= sclk;
    cs_q   <= cs_n;
    web_q  <= web;
  end

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < int'(SLOTS); i++) poke(4'(i), 32'h0);
  endtask

  task automatic start_run();
    rst_n = 1'b1;
    @(posedge clk); #1;
    run = 1'b1;
  endtask

  task automatic wait_fetch(output bit ok, output logic [7:0] a, output int unsigned c);
    int unsigned start;
    start = fetch_cnt;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk); #1;
      if (fetch_cnt != start) ok = 1'b1;
    end
    a = last_fetch_addr;
    c = last_fetch_cyc;
  endtask

  task automatic wait_wr(output bit ok);
    int unsigned start;
    start = wr_cnt;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk); #1;
      if (wr_cnt != start) ok = 1'b1;
    end
  endtask

  task automatic wait_cs_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk); #1;
      if (cs_n == 1'b0) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [3:0]  slot;
    logic [31:0] cmd;
    logic [7:0]  reply;
    logic [15:0] frame;
    logic [31:0] wb;
  } vec_t;
  vec_t vecs [NVEC];

  initial begin
    bit          ok;
    logic [7:0]  fa;
    logic [3:0]  nxt;
    int unsigned fc, pc, snap_r, snap_cs, snap;

    vecs[0] = '{4'd2,  32'hC05A0000, 8'h3C, 16'hDA00, 32'h605A003C};
    vecs[1] = '{4'd15, 32'h8012A500, 8'h77, 16'h12A5, 32'h2012A577};
    vecs[2] = '{4'd7,  32'h80FF0100, 8'hE1, 16'h7F01, 32'h20FF01E1};
    vecs[3] = '{4'd5,  32'h9F3300AB, 8'hC3, 16'h3300, 32'h3F3300C3};
    vecs[4] = '{4'd0,  32'hE1808100, 8'h0F, 16'h8081, 32'h6180810F};

    // Reset values and empty-slot polling
    do_reset();
    repeat (2) @(posedge clk); #1;
    check("reset_outputs", {enb, web, addrb, dib, sclk, cs_n, mosi, busy},
          {1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    snap_cs = cs_low;
    start_run();
    pc = 0;
    for (int i = 0; i < 17; i++) begin
      wait_fetch(ok, fa, fc);
      check($sformatf("poll%0d_seen", i), ok, 1);
      check($sformatf("poll%0d_addr", i), fa, 8'(i % 16));
      if (i > 0) check($sformatf("poll%0d_gap", i), fc - pc, 3);
      pc = fc;
    end
    check("poll_cs_idle", cs_low - snap_cs, 0);
    check("poll_busy", busy, 1);

    // Table of single pending commands
    for (int v = 0; v < int'(NVEC); v++) begin
      do_reset();
      poke(vecs[v].slot, vecs[v].cmd);
      slave_word = {8'hA5, vecs[v].reply};
      snap_r  = rises;
      snap_cs = cs_low;
      start_run();
      wait_wr(ok);
      check($sformatf("v%0d_wb_seen", v), ok, 1);
      wait_fetch(ok, fa, fc);
      check($sformatf("v%0d_next_fetch_seen", v), ok, 1);
      nxt = vecs[v].slot + 4'd1;
      check($sformatf("v%0d_frame", v), s_rx, vecs[v].frame);
      check($sformatf("v%0d_sclk_rises", v), rises - snap_r, 16);
      check($sformatf("v%0d_cs_low_cycles", v), cs_low - snap_cs, CS_LOW);
      check($sformatf("v%0d_slot_word", v), mem[vecs[v].slot], vecs[v].wb);
      check($sformatf("v%0d_wb_addr", v), last_wr_addr, {4'h0, vecs[v].slot});
      check($sformatf("v%0d_next_addr", v), fa, {4'h0, nxt});
      check($sformatf("v%0d_latency", v), fc - fetch_cyc_of[vecs[v].slot], PEND_LAT);
    end

    // run dropped while slot 3 is shifting
    do_reset();
    poke(4'd3, 32'hC0110000);
    slave_word = 16'h0099;
    start_run();
    wait_cs_low(ok);
    check("drop_cs_seen", ok, 1);
    repeat (20) @(posedge clk); #1;
    check("drop_busy_in_shift", busy, 1);
    run = 1'b0;
    wait_wr(ok);
    check("drop_wb_seen", ok, 1);
    repeat (4) @(posedge clk); #1;
    check("drop_busy_low", busy, 0);
    snap = enb_cnt;
    repeat (50) @(posedge clk); #1;
    check("drop_no_enb", enb_cnt - snap, 0);
    check("drop_slot3_word", mem[3], 32'h60110099);
    run = 1'b1;
    wait_fetch(ok, fa, fc);
    check("drop_resume_seen", ok, 1);
    check("drop_resume_addr", fa, 8'd4);

    // Reset asserted mid-transfer on slot 6
    do_reset();
    poke(4'd6, 32'hC0220000);
    slave_word = 16'h0055;
    start_run();
    wait_cs_low(ok);
    check("rst_cs_seen", ok, 1);
    repeat (40) @(posedge clk); #1;
    check("rst_sclk_high_before", sclk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pins_async", {cs_n, sclk, busy}, 3'b100);
    check("rst_slot_kept", mem[6], 32'hC0220000);
    snap = wr_cnt;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (400) @(posedge clk); #1;
    check("rst_single_exec", wr_cnt - snap, 1);
    check("rst_slot_word", mem[6], 32'h60220055);

`ifdef SPI_MBOX_IRQ_EN
    // Two pending slots produce two aligned irq pulses
    do_reset();
    poke(4'd1, 32'h80010200);
    poke(4'd9, 32'hC0030000);
    slave_word = 16'h0000;
    snap = irq_cnt;
    pc = irq_bad;
    start_run();
    repeat (500) @(posedge clk); #1;
    check("irq_pulses", irq_cnt - snap, 2);
    check("irq_alignment", irq_bad - pc, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_mbox_reader.md
# spi_mbox_reader

SPI-side consumer of the dual-port command mailbox RAM. It polls RAM port B for command words posted by the Wishbone side and executes each one as a 16-bit SPI mode-0 transfer. It then writes the completed word, with the received byte, back into the same slot. It is the reader/executor end of the port-A-write / port-B-read mailbox, and sits between RAM port B and the external SPI pins.

## Interface
Parameters:
- SLOTS, 16: number of mailbox slots polled, addresses 0..SLOTS-1 (1..256).
- CLK_DIV, 4: SCLK half-period in clk cycles (>=1).

Ports:
- clk  in  1  single clock; also drives RAM port B (clkb).
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  polling enable.
- enb  out  1  RAM port B enable.
- web  out  1  RAM port B write enable.
- addrb  out  8  RAM port B address.
- dib  out  32  write-back word.
- dob  in  32  RAM read data.
- ackb  in  1  RAM ack; high the cycle after enb.
- sclk  out  1  SPI clock, idle low.
- cs_n  out  1  SPI chip select, idle high.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in.
- busy  out  1  high outside IDLE.

## Operation
- Command word: bit31 = pending, bit30 = rw (1 = read), bit29 = done, bits23:16 = SPI address byte A, bits15:8 = write data D, others reserved.
- SPI frame: 16 bits, MSB first. Frame bit 15 = rw, bits 14:8 = A[6:0], bits 7:0 = D.
- The received byte is the low 8 frame bits sampled on MISO.
- FSM states: IDLE, FETCH, WAIT_RD, DECODE, SHIFT, WRBACK, WAIT_WR.
- IDLE: go to FETCH when run=1.
- FETCH: drive enb=1, web=0, addrb=ptr for one cycle, then go to WAIT_RD.
- WAIT_RD: wait for ackb=1; latch dob into cmd. The RAM always acks in 1 cycle; ackb is not timed out.
- DECODE: if cmd[31]=0, advance ptr and return to FETCH (or IDLE if run=0). Otherwise go to SHIFT.
- SHIFT: run the SPI transfer (see Timing), capture rx[7:0].
- WRBACK: drive enb=1, web=1, addrb=ptr, dib = {1'b0, cmd[30], 1'b1, cmd[28:8], rx}, for one cycle.
- WAIT_WR: wait for ackb, advance ptr, return to FETCH (or IDLE if run=0).
- ptr advance: ptr+1, wrapping to 0 after SLOTS-1.
- run=0 mid-transaction: the current slot always completes through WAIT_WR before parking in IDLE; ptr is kept.
- The write-back is performed for write commands too; rx holds MISO junk and software ignores it.
- enb/web are never both asserted outside FETCH/WRBACK.
- Simultaneous port-A write to the same slot during SHIFT: the write-back overwrites it. The Wishbone side must not touch slots with pending=1.

## Timing
- Reset values: enb=0, web=0, addrb=0, dib=0, sclk=0, cs_n=1, mosi=0, busy=0, ptr=0, state IDLE.
- Reset is asynchronous; asserting it mid-SHIFT drops cs_n high and sclk low immediately.
- A slot interrupted by reset keeps pending=1 and is re-executed after reset.
- Empty-slot poll: 3 cycles per slot (FETCH, WAIT_RD, DECODE).
- SHIFT sequence:
  - Entry cycle: cs_n=0, mosi=frame[15].
  - After each CLK_DIV cycles, sclk toggles; 32 toggles in total.
  - Rising edges sample miso; falling edges shift out the next mosi bit.
  - After the 32nd toggle (sclk low), cs_n stays low CLK_DIV cycles, then goes high.
  - SHIFT duration is 34*CLK_DIV cycles.
- Pending-slot latency, FETCH to return to FETCH: 3 + 34*CLK_DIV + 2 cycles. This is 141 cycles at CLK_DIV=4.
- busy=1 from the cycle after leaving IDLE until IDLE is re-entered.

## Configuration
- SPI_MBOX_IRQ_EN defined:
  - Adds output port irq (1 bit, reset 0).
  - irq pulses high for exactly one cycle in the WAIT_WR cycle where ackb=1.
- Not defined: no irq port and no related logic.

## Test plan
- Reset, run=1, all slots 0: addrb sequences 0,1,…,15,0; enb pulses every 3 cycles; cs_n stays 1.
- Slot 2 = 0xC0_5A_00_00 (pending read, A=0x5A), slave returns 0x3C, CLK_DIV=4:
  - mosi frame = 0xDA00.
  - Slot 2 becomes 0x605A003C.
  - Exactly 16 sclk rising edges.
  - cs_n low for 136 cycles.
- Slot 15 = 0x80_12_A5_00 (pending write): frame 0x12A5, slot 15 written back with bit31=0, bit29=1, then ptr wraps to 0.
- run dropped during SHIFT on slot 3: transfer and write-back complete, busy falls, no further enb until run=1; polling resumes at slot 4.
- rst_n asserted mid-SHIFT: cs_n=1, sclk=0, busy=0 in the same cycle. After release with run=1, the same slot is fetched again at its turn and executed once.
- With SPI_MBOX_IRQ_EN, two pending slots: exactly two 1-cycle irq pulses, each coincident with a write-back ackb.
